// File: rtl/add16_seq_pkg.sv
// ---------------------------------------------------------------------------
// add16_seq_pkg
// Shared definitions for the nibble-serial adder sequencer.
//   NIB_W              : width of one datapath slice (one adder_4bit cell)
//   ST_IDLE/RUN/DONE   : FSM state encoding
//   state_t            : enumerated FSM state type built on that encoding
// ---------------------------------------------------------------------------
package add16_seq_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/add16_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// add16_seq_ctrl_if
// Operand/result handshake bundle for add16_seq_ctrl.
//   in_valid/in_ready   : operand handshake (a, b, c_in)
//   out_valid/out_ready : result handshake (sum, c_out, ovf)
//   busy                : sequencer is running or holding a result
// Modports:
//   master : the operand source / result consumer side
//   slave  : the sequencer side
// ---------------------------------------------------------------------------
interface add16_seq_ctrl_if #(
  parameter int WORDS = 4
);
  localparam int W = add16_seq_pkg::NIB_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );

endinterface

// File: rtl/add16_seq_ctrl_adder.sv
// ---------------------------------------------------------------------------
// adder_4bit
// Purely combinational 4-bit adder cell with carry in/out.
//   a, b : 4-bit addends
//   cin  : carry in
//   s    : 4-bit sum
//   cout : carry out
// ---------------------------------------------------------------------------
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/add16_seq_ctrl.sv
// ---------------------------------------------------------------------------
// add16_seq_ctrl
// Nibble-serial adder: computes a + b + c_in over WORDS nibbles using one
// shared adder_4bit, LSB nibble first, one nibble per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : add16_seq_ctrl_if slave (operand and result handshakes,
//         sum / c_out / ovf result, busy status)
// Parameter:
//   WORDS : nibbles per operand (2..8), operand width = 4*WORDS
// ---------------------------------------------------------------------------
module add16_seq_ctrl
  import add16_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  add16_seq_ctrl_if.slave        bus
);

  localparam int W   = NIB_W * WORDS;
  localparam int K_W = $clog2(WORDS);
  localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

  state_t         state_reg, state_next;
  logic [W-1:0]   a_reg, a_next;
  logic [W-1:0]   b_reg, b_next;
  logic           carry_reg, carry_next;
  logic [K_W-1:0] k_reg, k_next;
  logic [W-1:0]   sum_reg, sum_next;
  logic           c_out_reg, c_out_next;
  logic           ovf_reg, ovf_next;

  // Nibble views of the latched operands, and the sum with the current
  // nibble replaced by the adder result.
  logic [NIB_W-1:0] a_nib [WORDS];
  logic [NIB_W-1:0] b_nib [WORDS];
  logic [W-1:0]     sum_upd;

  logic [NIB_W-1:0] add_s;
  logic             add_co;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[gi*NIB_W +: NIB_W];
      assign b_nib[gi] = b_reg[gi*NIB_W +: NIB_W];
      assign sum_upd[gi*NIB_W +: NIB_W] =
        (k_reg == K_W'(gi)) ? add_s : sum_reg[gi*NIB_W +: NIB_W];
    end
  endgenerate

  // The single shared datapath cell, steered by the nibble index.
  adder_4bit u_adder (
    .a    (a_nib[k_reg]),
    .b    (b_nib[k_reg]),
    .cin  (carry_reg),
    .s    (add_s),
    .cout (add_co)
  );

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    carry_next = carry_reg;
    k_next     = k_reg;
    sum_next   = sum_reg;
    c_out_next = c_out_reg;
    ovf_next   = ovf_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.a;
          b_next     = bus.b;
          carry_next = bus.c_in;
          k_next     = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        sum_next   = sum_upd;
        carry_next = add_co;
        if (k_reg == K_LAST) begin
          // Final nibble: add_s[NIB_W-1] is the new sign bit of the sum.
          c_out_next = add_co;
          ovf_next   = (a_reg[W-1] == b_reg[W-1]) &&
                       (add_s[NIB_W-1] != a_reg[W-1]);
          state_next = DONE;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Latched operands are cleared too so an aborted job leaves no trace.
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      k_reg     <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      carry_reg <= carry_next;
      k_reg     <= k_next;
      sum_reg   <= sum_next;
      c_out_reg <= c_out_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg == RUN) || (state_reg == DONE);
  assign bus.sum       = sum_reg;
  assign bus.c_out     = c_out_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: doc/add16_seq_ctrl.md
Name: add16_seq_ctrl

Overview:
- Nibble-serial sequencer that adds two WORDS*4-bit operands (16-bit by default) using one shared adder_4bit instance.
- It processes one nibble per clock, LSB nibble first, and carries between nibbles through a carry register.
- It sits between an upstream operand source and a downstream result consumer, with a valid/ready handshake on both sides.
- It is the area-reduced alternative to the 16-bit ripple adder: one adder cell plus control, instead of four cascaded cells.

Parameters:
- WORDS, 4, number of 4-bit nibbles per operand. Operand width W = 4*WORDS. Legal range 2..8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b, c_in are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  W  operand A (unsigned or two's complement)
- b  input  W  operand B
- c_in  input  1  carry into nibble 0
- out_valid  output  1  sum, c_out and ovf are valid
- out_ready  input  1  consumer accepts the result
- sum  output  W  A+B+c_in, modulo 2^W
- c_out  output  1  carry out of the MSB nibble
- ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN and DONE

Behaviour:
- Reset: a synchronous rst on a clock edge forces state=IDLE and clears the following: in_ready=1 after reset, out_valid=0, busy=0, sum=0, c_out=0, ovf=0, nibble index=0, carry reg=0. Reset takes priority in every state.
- Reset mid-operation: a reset during RUN or DONE aborts the transaction. No out_valid is produced for it, and latched operands are discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On an edge where in_valid=1, latch a, b and c_in, set carry reg=c_in and k=0, then go to RUN.
  - RUN: in_ready=0. The adder is fed a[4k+3:4k], b[4k+3:4k] and the carry reg.
    - Each edge writes the adder sum into sum[4k+3:4k] and the adder carry-out into the carry reg, then increments k.
    - When k=WORDS-1, that edge also sets c_out = adder carry-out and ovf = (a[W-1]==b[W-1]) && (new sum[W-1]!=a[W-1]), then goes to DONE.
  - DONE: out_valid=1. On an edge where out_ready=1, go to IDLE with out_valid=0.
- Latency: out_valid is visible in the cycle after the WORDS-th edge following the accept edge. The default is 4 cycles after acceptance.
- Throughput: at most one transaction per WORDS+2 cycles. in_ready is low throughout DONE, so there is no accept in the same cycle as result hand-off.
- Backpressure: while out_valid=1 and out_ready=0, sum, c_out and ovf hold stable indefinitely.
- Input isolation:
  - in_valid and the a/b/c_in inputs are ignored whenever in_ready=0.
  - Input changes after acceptance do not affect the result, because operands are latched.
- Output values:
  - sum, c_out and ovf are updated only in RUN. They retain the last result in IDLE until the next transaction overwrites them.
  - Partial nibbles of sum may be observed during RUN and are not valid until out_valid=1.
- Width rule: arithmetic is modulo 2^W. The carry out of the MSB nibble goes only to c_out.
- Nibble index: k is clog2(WORDS) bits wide and never wraps past WORDS-1 inside RUN.

Decomposition:
- Shared package/header add16_seq_pkg holds:
  - the state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - NIB_W=4.
- One sub-module: the existing adder_4bit, instantiated exactly once as the shared datapath.
- Nibble selection (a mux on k) and the registers stay in add16_seq_ctrl.

Test Plan:
1. a=0x1234, b=0x4321, c_in=0, out_ready=1 → out_valid 4 cycles after accept; sum=0x5555, c_out=0, ovf=0; in_ready returns to 1 the cycle after hand-off.
2. a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0. Checks carry propagation through all nibbles.
3. a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, ovf=1. Then a=0x8000, b=0x8000 → sum=0x0000, c_out=1, ovf=1.
4. a=0x0FFF, b=0x0000, c_in=1 → sum=0x1000, c_out=0. During RUN, toggle in_valid and change a/b; the result is unchanged and no second accept occurs.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid → sum, c_out, ovf and out_valid stable. On raising out_ready, exactly one hand-off, then IDLE.
6. Assert rst for 1 cycle at the 2nd RUN cycle of a=0xAAAA, b=0x5555 → next cycle: IDLE, in_ready=1, out_valid=0, sum=0. A following transaction 0x0001+0x0002 completes with sum=0x0003.
